// File: rtl/ps2_direction_decoder.sv
// ps2_direction_decoder: turns PS/2 set-2 scan codes into light-cycle controls.
// Tracks make/break/extended prefixes and allows at most one turn per player per tick.
module ps2_direction_decoder #(
    parameter logic [1:0] P1_INIT_DIR    = 2'd1,
    parameter logic [1:0] P2_INIT_DIR    = 2'd3,
    parameter int         PREFIX_TIMEOUT = 50000,
    parameter int         TO_W           = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] code_byte,
    input  logic       code_valid,
    input  logic       game_tick,
    output logic [1:0] p1_dir,
    output logic [1:0] p2_dir,
    output logic       start_pulse,
    output logic       paused,
    output logic       game_reset_pulse
);

    localparam logic [7:0] CODE_EXT   = 8'hE0;
    localparam logic [7:0] CODE_BRK   = 8'hF0;
    localparam logic [7:0] KEY_W      = 8'h1D;
    localparam logic [7:0] KEY_D      = 8'h23;
    localparam logic [7:0] KEY_S      = 8'h1B;
    localparam logic [7:0] KEY_A      = 8'h1C;
    localparam logic [7:0] KEY_UP     = 8'h75;
    localparam logic [7:0] KEY_RIGHT  = 8'h74;
    localparam logic [7:0] KEY_DOWN   = 8'h72;
    localparam logic [7:0] KEY_LEFT   = 8'h6B;
    localparam logic [7:0] KEY_SPACE  = 8'h29;
    localparam logic [7:0] KEY_P      = 8'h4D;
    localparam logic [7:0] KEY_ESC    = 8'h76;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(PREFIX_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        EXT,
        BRK,
        EXT_BRK
    } state_t;

    state_t          state;
    state_t          stateNext;
    logic [TO_W-1:0] toCnt;
    logic [TO_W-1:0] toCntNext;

    logic plainMake;
    logic extMake;
    logic plainBreak;

    logic spaceHeld;
    logic pauseHeld;
    logic escHeld;

    logic spaceFire;
    logic pauseFire;
    logic escFire;

    logic       p1Req;
    logic [1:0] p1Cand;
    logic       p2Req;
    logic [1:0] p2Cand;

    logic [1:0] p1Pend;
    logic       p1PendValid;
    logic [1:0] p2Pend;
    logic       p2PendValid;

    logic [1:0] p1Ref;
    logic [1:0] p2Ref;
    logic       p1Take;
    logic       p2Take;

    function automatic logic turnOk(input logic [1:0] cand,
                                    input logic [1:0] cur);
        return (cand != cur) && (cand != (cur ^ 2'b10));
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            toCnt <= '0;
        end else begin
            state <= stateNext;
            toCnt <= toCntNext;
        end
    end

    // A fresh byte always restarts the prefix timeout; timeout only matters
    // while a prefix is waiting for its follow-up byte.
    always_comb begin
        stateNext  = state;
        toCntNext  = toCnt;
        plainMake  = 1'b0;
        extMake    = 1'b0;
        plainBreak = 1'b0;
        if (code_valid) begin
            toCntNext = '0;
            unique case (state)
                IDLE: begin
                    if (code_byte == CODE_EXT) begin
                        stateNext = EXT;
                    end else if (code_byte == CODE_BRK) begin
                        stateNext = BRK;
                    end else begin
                        plainMake = 1'b1;
                    end
                end
                EXT: begin
                    if (code_byte == CODE_BRK) begin
                        stateNext = EXT_BRK;
                    end else if (code_byte != CODE_EXT) begin
                        extMake   = 1'b1;
                        stateNext = IDLE;
                    end
                end
                BRK: begin
                    plainBreak = 1'b1;
                    stateNext  = IDLE;
                end
                EXT_BRK: begin
                    stateNext = IDLE;
                end
                default: stateNext = IDLE;
            endcase
        end else if (state != IDLE) begin
            if (toCnt == TO_LAST) begin
                stateNext = IDLE;
                toCntNext = '0;
            end else begin
                toCntNext = toCnt + 1'b1;
            end
        end
    end

    always_comb begin
        p1Req  = 1'b0;
        p1Cand = 2'd0;
        if (plainMake) begin
            unique case (1'b1)
                code_byte == KEY_W: begin p1Req = 1'b1; p1Cand = 2'd0; end
                code_byte == KEY_D: begin p1Req = 1'b1; p1Cand = 2'd1; end
                code_byte == KEY_S: begin p1Req = 1'b1; p1Cand = 2'd2; end
                code_byte == KEY_A: begin p1Req = 1'b1; p1Cand = 2'd3; end
                default: ;
            endcase
        end
    end

    always_comb begin
        p2Req  = 1'b0;
        p2Cand = 2'd0;
        if (extMake) begin
            unique case (1'b1)
                code_byte == KEY_UP:    begin p2Req = 1'b1; p2Cand = 2'd0; end
                code_byte == KEY_RIGHT: begin p2Req = 1'b1; p2Cand = 2'd1; end
                code_byte == KEY_DOWN:  begin p2Req = 1'b1; p2Cand = 2'd2; end
                code_byte == KEY_LEFT:  begin p2Req = 1'b1; p2Cand = 2'd3; end
                default: ;
            endcase
        end
    end

    assign spaceFire = plainMake && code_byte == KEY_SPACE && !spaceHeld;
    assign pauseFire = plainMake && code_byte == KEY_P && !pauseHeld;
    assign escFire   = plainMake && code_byte == KEY_ESC && !escHeld;

    // Judge turns against the direction that is in force after this edge.
    assign p1Ref  = (game_tick && p1PendValid) ? p1Pend : p1_dir;
    assign p2Ref  = (game_tick && p2PendValid) ? p2Pend : p2_dir;
    assign p1Take = p1Req && !paused && turnOk(p1Cand, p1Ref);
    assign p2Take = p2Req && !paused && turnOk(p2Cand, p2Ref);

    always_ff @(posedge clk) begin
        if (rst) begin
            spaceHeld <= 1'b0;
            pauseHeld <= 1'b0;
            escHeld   <= 1'b0;
        end else begin
            if (plainMake && code_byte == KEY_SPACE) begin
                spaceHeld <= 1'b1;
            end else if (plainBreak && code_byte == KEY_SPACE) begin
                spaceHeld <= 1'b0;
            end
            if (plainMake && code_byte == KEY_P) begin
                pauseHeld <= 1'b1;
            end else if (plainBreak && code_byte == KEY_P) begin
                pauseHeld <= 1'b0;
            end
            if (plainMake && code_byte == KEY_ESC) begin
                escHeld <= 1'b1;
            end else if (plainBreak && code_byte == KEY_ESC) begin
                escHeld <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p1_dir           <= P1_INIT_DIR;
            p2_dir           <= P2_INIT_DIR;
            p1Pend           <= 2'd0;
            p1PendValid      <= 1'b0;
            p2Pend           <= 2'd0;
            p2PendValid      <= 1'b0;
            paused           <= 1'b0;
            start_pulse      <= 1'b0;
            game_reset_pulse <= 1'b0;
        end else begin
            start_pulse      <= spaceFire;
            game_reset_pulse <= escFire;
            if (escFire) begin
                p1_dir      <= P1_INIT_DIR;
                p2_dir      <= P2_INIT_DIR;
                p1PendValid <= 1'b0;
                p2PendValid <= 1'b0;
                paused      <= 1'b0;
            end else begin
                if (pauseFire) begin
                    paused <= ~paused;
                end
                if (game_tick && p1PendValid) begin
                    p1_dir      <= p1Pend;
                    p1PendValid <= 1'b0;
                end
                if (p1Take) begin
                    p1Pend      <= p1Cand;
                    p1PendValid <= 1'b1;
                end
                if (game_tick && p2PendValid) begin
                    p2_dir      <= p2Pend;
                    p2PendValid <= 1'b0;
                end
                if (p2Take) begin
                    p2Pend      <= p2Cand;
                    p2PendValid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_direction_decoder.sv
// tb_ps2_direction_decoder: directed plus random byte streams, scored per
// cycle against a keyboard/game model kept in the bench.
module tb_ps2_direction_decoder;

    localparam int PT = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] code_byte = 8'h00;
    logic       code_valid = 1'b0;
    logic       game_tick = 1'b0;
    logic [1:0] p1_dir;
    logic [1:0] p2_dir;
    logic       start_pulse;
    logic       paused;
    logic       game_reset_pulse;

    ps2_direction_decoder #(
        .P1_INIT_DIR(2'd1),
        .P2_INIT_DIR(2'd3),
        .PREFIX_TIMEOUT(PT),
        .TO_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .code_byte(code_byte),
        .code_valid(code_valid),
        .game_tick(game_tick),
        .p1_dir(p1_dir),
        .p2_dir(p2_dir),
        .start_pulse(start_pulse),
        .paused(paused),
        .game_reset_pulse(game_reset_pulse)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int failures = 0;
    int cyc = 0;

    logic [6:0] expQ[$];

    // Model state: directions as integers 0..3, pending -1 when none.
    int mP1, mP2, mPend1, mPend2;
    bit mPaused, mStart, mGrp;
    bit mExt, mBrk;
    int mGap;
    bit held[256];

    function automatic void modelReset();
        mP1 = 1; mP2 = 3; mPend1 = -1; mPend2 = -1;
        mPaused = 0; mStart = 0; mGrp = 0;
        mExt = 0; mBrk = 0; mGap = 0;
        foreach (held[i]) held[i] = 0;
    endfunction

    function automatic void tryTurn(int who, int cand);
        int cur;
        cur = (who == 1) ? mP1 : mP2;
        if (mPaused || cand == cur || cand == (cur + 2) % 4) return;
        if (who == 1) mPend1 = cand;
        else mPend2 = cand;
    endfunction

    function automatic void doMake(logic [7:0] b, bit ext);
        if (!ext) begin
            case (b)
                8'h1D: tryTurn(1, 0);
                8'h23: tryTurn(1, 1);
                8'h1B: tryTurn(1, 2);
                8'h1C: tryTurn(1, 3);
                8'h29: if (!held[b]) mStart = 1;
                8'h4D: if (!held[b]) mPaused = !mPaused;
                8'h76: if (!held[b]) begin
                    mGrp = 1; mP1 = 1; mP2 = 3;
                    mPend1 = -1; mPend2 = -1; mPaused = 0;
                end
                default: ;
            endcase
            held[b] = 1;
        end else begin
            case (b)
                8'h75: tryTurn(2, 0);
                8'h74: tryTurn(2, 1);
                8'h72: tryTurn(2, 2);
                8'h6B: tryTurn(2, 3);
                default: ;
            endcase
        end
    endfunction

    function automatic void modelStep(bit r, bit v, logic [7:0] b, bit t);
        mStart = 0;
        mGrp = 0;
        if (r) begin
            modelReset();
            return;
        end
        if (t && mPend1 >= 0) begin mP1 = mPend1; mPend1 = -1; end
        if (t && mPend2 >= 0) begin mP2 = mPend2; mPend2 = -1; end
        if (v) begin
            mGap = 0;
            if (mBrk) begin
                if (!mExt) held[b] = 0;
                mExt = 0; mBrk = 0;
            end else if (b == 8'hE0) begin
                mExt = 1;
            end else if (b == 8'hF0) begin
                mBrk = 1;
            end else begin
                doMake(b, mExt);
                mExt = 0;
            end
        end else if (mExt || mBrk) begin
            mGap++;
            if (mGap == PT) begin
                mExt = 0; mBrk = 0; mGap = 0;
            end
        end
    endfunction

    task automatic cycle(input bit v, input logic [7:0] b,
                         input bit t, input bit r);
        logic [6:0] e;
        @(negedge clk);
        code_valid = v;
        code_byte  = b;
        game_tick  = t;
        rst        = r;
        modelStep(r, v, b, t);
        e = {mP1[1:0], mP2[1:0], mStart, mPaused, mGrp};
        expQ.push_back(e);
    endtask

    task automatic key(input logic [7:0] b);
        cycle(1, b, 0, 0);
    endtask

    task automatic tick();
        cycle(0, 8'h00, 1, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 8'h00, 0, 0);
    endtask

    task automatic chk(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    // Monitor: every post-edge output set is scored against the queue.
    initial begin
        logic [6:0] e;
        logic [6:0] g;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                g = {p1_dir, p2_dir, start_pulse, paused, game_reset_pulse};
                tests++;
                if (g !== e) begin
                    failures++;
                    $display("FAIL outputs cyc %0d: got p1=%0d p2=%0d st=%b pa=%b gr=%b expected p1=%0d p2=%0d st=%b pa=%b gr=%b",
                             cyc, g[6:5], g[4:3], g[2], g[1], g[0],
                             e[6:5], e[4:3], e[2], e[1], e[0]);
                end
            end
        end
    end

    initial begin
        logic [7:0] pool [14];
        logic [7:0] b;
        bit r, v, t;
        int k;
        pool = '{8'hE0, 8'hF0, 8'h1D, 8'h23, 8'h1B, 8'h1C, 8'h75,
                 8'h74, 8'h72, 8'h6B, 8'h29, 8'h4D, 8'h76, 8'hF0};
        modelReset();

        cycle(0, 8'h00, 0, 1);
        cycle(0, 8'h00, 0, 1);
        idle(1);
        chk("reset p1", p1_dir, 1);
        chk("reset p2", p2_dir, 3);

        key(8'h1D); key(8'hF0); key(8'h1D);
        idle(1);
        chk("p1 before tick", p1_dir, 1);
        tick(); idle(1);
        chk("p1 up after tick", p1_dir, 0);
        chk("p2 unchanged", p2_dir, 3);

        cycle(0, 8'h00, 0, 1);
        key(8'h1C); tick(); idle(1);
        chk("p1 reversal rejected", p1_dir, 1);
        key(8'h1D); key(8'h1B); tick(); idle(1);
        chk("p1 last wins", p1_dir, 2);

        key(8'hE0); key(8'h72); tick(); idle(1);
        chk("p2 down", p2_dir, 2);
        key(8'hE0); key(8'hF0); key(8'h72); tick(); idle(1);
        chk("p2 ext break", p2_dir, 2);
        key(8'hE0); idle(PT - 1); key(8'h74); tick(); idle(1);
        chk("p2 just before timeout", p2_dir, 1);
        key(8'hE0); idle(PT); key(8'h6B); tick(); idle(1);
        chk("p2 after timeout", p2_dir, 1);

        key(8'h29); key(8'h29); key(8'h29);
        key(8'hF0); key(8'h29); key(8'h29);
        key(8'hF0); key(8'h29);
        key(8'h4D); key(8'h4D); idle(1);
        chk("pause once", paused, 1);
        key(8'hF0); key(8'h4D); key(8'h4D); idle(1);
        chk("pause toggled back", paused, 0);
        key(8'hF0); key(8'h4D);

        cycle(0, 8'h00, 0, 1);
        key(8'h1D);
        cycle(1, 8'h1C, 1, 0);
        idle(1);
        chk("p1 committed up", p1_dir, 0);
        tick(); idle(1);
        chk("p1 left after up", p1_dir, 3);

        key(8'h4D); idle(1);
        chk("paused set", paused, 1);
        cycle(1, 8'h76, 1, 0);
        idle(1);
        chk("game reset p1", p1_dir, 1);
        chk("game reset p2", p2_dir, 3);
        chk("game reset paused", paused, 0);
        key(8'hF0); key(8'h76); key(8'hF0); key(8'h4D);

        key(8'hE0);
        cycle(0, 8'h00, 0, 1);
        key(8'hF0); key(8'h29);
        key(8'h29); idle(1);
        chk("rst mid prefix", p1_dir, 1);

        for (int n = 0; n < 4000; n++) begin
            r = ($urandom_range(0, 599) == 0);
            v = $urandom_range(0, 1) == 1;
            k = $urandom_range(0, 15);
            b = (k < 14) ? pool[k] : 8'($urandom);
            t = ($urandom_range(0, 7) == 0);
            cycle(v, b, t, r);
            if ($urandom_range(0, 149) == 0)
                idle(PT - 1 + $urandom_range(0, 2));
        end

        idle(2);
        for (int i = 0; i < 10 && expQ.size() > 0; i++) @(posedge clk);
        #2;
        tests++;
        if (expQ.size() > 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", expQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
